// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Parametrised multi-port register file with optional write-to-read
//            bypass and a per-register pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH   = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [AW-1:0]        A3,
    input  logic [WIDTH-1:0]     WD3,
    input  logic [NRD*AW-1:0]    RA,
    output logic [NRD*WIDTH-1:0] RD,
    input  logic                 IssueEn,
    input  logic [AW-1:0]        IssueAddr,
    output logic [NRD-1:0]       Busy,
    output logic                 Stall,
    output logic [AW:0]          PendCnt
);

    localparam int c_nreg    = 2**AW;
    localparam bit c_bypass  = (BYPASS != 0);
    localparam bit c_zero_r0 = (ZERO_R0 != 0);

    logic [WIDTH-1:0]  r_regs [c_nreg];
    logic [c_nreg-1:0] r_sb;
    logic [c_nreg-1:0] w_sb_next;
    logic [AW:0]       r_pend_cnt;
    logic [AW:0]       w_pend_next;
    logic              w_wr_ok;

    assign w_wr_ok = RegWrite && !(c_zero_r0 && (A3 == '0));

    // Clear before set so an issue in the writeback edge keeps the new writer pending.
    always_comb begin
        w_sb_next = r_sb;
        if (RegWrite) begin
            w_sb_next[A3] = 1'b0;
        end
        if (IssueEn) begin
            w_sb_next[IssueAddr] = 1'b1;
        end
        if (c_zero_r0) begin
            w_sb_next[0] = 1'b0;
        end
    end

    always_comb begin
        w_pend_next = '0;
        for (int k = 0; k < c_nreg; k++) begin
            w_pend_next = w_pend_next + {{AW{1'b0}}, w_sb_next[k]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < c_nreg; k++) begin
                r_regs[k] <= '0;
            end
            r_sb       <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[A3] <= WD3;
            end
            r_sb       <= w_sb_next;
            r_pend_cnt <= w_pend_next;
        end
    end

    assign PendCnt = r_pend_cnt;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_r0;
            logic          w_hit;

            assign w_ra  = RA[i*AW +: AW];
            assign w_r0  = c_zero_r0 && (w_ra == '0);
            assign w_hit = w_wr_ok && (A3 == w_ra);

            assign RD[i*WIDTH +: WIDTH] = (reset || w_r0)     ? '0  :
                                          (c_bypass && w_hit) ? WD3 :
                                                                r_regs[w_ra];

            // Without bypass the write cycle itself still counts as a hazard.
            assign Busy[i] = !reset && !w_r0 &&
                             (c_bypass ? (r_sb[w_ra] && !w_hit)
                                       : (r_sb[w_ra] || w_hit));
        end
    endgenerate

    assign Stall = |Busy;

endmodule
`default_nettype wire
